// File: rtl/cla_pkg.sv
// Shared definitions for the CLA adder core and its streaming shell.
package cla_pkg;

    localparam int CLA_WIDTH = 32;
    localparam int CLA_LAT   = 2;

    typedef struct packed {
        logic                 carry;
        logic [CLA_WIDTH-1:0] sum;
    } cla_result_t;

endpackage

// File: rtl/cla_result_fifo.sv
// Circular-buffer FIFO of adder results with head peek and occupancy count.
module cla_result_fifo
    import cla_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int PW    = $clog2(DEPTH),
    localparam int CW    = PW + 1
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          push,
    input  cla_result_t   push_data,
    input  logic          pop,
    output cla_result_t   head,
    output logic [CW-1:0] count,
    output logic          valid
);

    cla_result_t   mem_r [DEPTH];
    logic [PW-1:0] wr_ptr_r;
    logic [PW-1:0] rd_ptr_r;
    logic [CW-1:0] count_r;
    logic [CW-1:0] count_next_s;
    logic          valid_r;
    logic          pop_s;

    // A pop is only honoured when an entry is actually present.
    always_comb begin
        pop_s = pop & valid_r;
    end

    // Next occupancy; simultaneous push and pop leaves it unchanged.
    always_comb begin
        count_next_s = count_r;
        case ({push, pop_s})
            2'b10:   count_next_s = count_r + CW'(1);
            2'b01:   count_next_s = count_r - CW'(1);
            default: count_next_s = count_r;
        endcase
    end

    // Storage, pointers and occupancy; pointers wrap naturally at DEPTH.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            mem_r    <= '{default: '0};
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
            valid_r  <= 1'b0;
        end else begin
            if (push) begin
                mem_r[wr_ptr_r] <= push_data;
                wr_ptr_r        <= wr_ptr_r + PW'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PW'(1);
            end
            count_r <= count_next_s;
            valid_r <= (count_next_s != CW'(0));
        end
    end

    assign head  = mem_r[rd_ptr_r];
    assign count = count_r;
    assign valid = valid_r;

endmodule

// File: rtl/cla_stream_shell.sv
// Valid/ready wrapper around the registered CLA adder core; credits guarantee
// every accepted operand pair has a FIFO slot waiting when its sum arrives.
module cla_stream_shell
    import cla_pkg::*;
#(
    parameter  int WIDTH = CLA_WIDTH,
    parameter  int DEPTH = 4,
    parameter  int LAT   = CLA_LAT,
    localparam int CW    = $clog2(DEPTH) + 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic [WIDTH-1:0] core_a,
    output logic [WIDTH-1:0] core_b,
    output logic             core_reset,
    input  logic [WIDTH-1:0] core_sum,
    input  logic             core_cout,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_carry,
    output logic [CW-1:0]    inflight
);

    logic [LAT-1:0] vpipe_r;
    logic [CW-1:0]  vpipe_cnt_s;
    logic [CW-1:0]  fifo_count_s;
    logic [CW-1:0]  inflight_s;
    logic           fire_in_s;
    logic           fire_out_s;
    logic           fifo_valid_s;
    cla_result_t    push_data_s;
    cla_result_t    head_s;

    // Credit check uses only registered occupancy, never in_valid or out_ready.
    always_comb begin
        vpipe_cnt_s = '0;
        for (int i = 0; i < LAT; i++) begin
            vpipe_cnt_s = vpipe_cnt_s + CW'(vpipe_r[i]);
        end
        inflight_s = fifo_count_s + vpipe_cnt_s;
        in_ready   = (inflight_s < CW'(DEPTH));
        fire_in_s  = in_valid & in_ready;
        fire_out_s = fifo_valid_s & out_ready;
    end

    // Operands reach the core only on an accepted pair; the core registers them.
    always_comb begin
        if (fire_in_s) begin
            core_a = in_a;
            core_b = in_b;
        end else begin
            core_a = '0;
            core_b = '0;
        end
    end

    // Valid pipeline tracks which core outputs belong to accepted pairs.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            vpipe_r <= '0;
        end else begin
            vpipe_r <= {vpipe_r[LAT-2:0], fire_in_s};
        end
    end

    assign push_data_s = '{carry: core_cout, sum: core_sum};

    cla_result_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (vpipe_r[LAT-1]),
        .push_data (push_data_s),
        .pop       (fire_out_s),
        .head      (head_s),
        .count     (fifo_count_s),
        .valid     (fifo_valid_s)
    );

    assign core_reset = ~reset;
    assign out_valid  = fifo_valid_s;
    assign out_sum    = head_s.sum;
    assign out_carry  = head_s.carry;
    assign inflight   = inflight_s;

endmodule
